// File: rtl/calc_key_sequencer.sv
// Key-to-command sequencer for the calculator: buffers one key, emits ordered register pulses,
// and runs the ALU start/done handshake with a watchdog and error lockout.
module calc_key_sequencer #(
   parameter int ALU_TIMEOUT = 64
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       key_valid_i,
   input  logic [4:0] key_code_i,
   output logic       key_ready_o,
   output logic       key_lost_o,
   output logic       newhex_o,
   output logic [3:0] hexcode_o,
   output logic       newop_o,
   output logic       eq_o,
   output logic       BS_o,
   output logic       CE_o,
   output logic [1:0] op_sel_o,
   output logic       alu_start_o,
   input  logic       alu_done_i,
   input  logic       alu_ovf_i,
   output logic       busy_o,
   output logic       err_o
);

   localparam int WDW = $clog2(ALU_TIMEOUT + 1);

   localparam logic [4:0] KEY_ADD = 5'h10;
   localparam logic [4:0] KEY_MUL = 5'h12;
   localparam logic [4:0] KEY_EQ  = 5'h13;
   localparam logic [4:0] KEY_BS  = 5'h14;
   localparam logic [4:0] KEY_CE  = 5'h15;

   typedef enum logic [2:0] {IDLE, START, WAIT, COMMIT_EQ, COMMIT_OP, ERROR} state_t;

   state_t           state_q, state_d;
   logic             bufValid_q, bufValid_d;
   logic [4:0]       bufCode_q, bufCode_d;
   logic             keyLost_q, keyLost_d;
   logic             newhex_q, newhex_d;
   logic [3:0]       hexcode_q, hexcode_d;
   logic             newop_q, newop_d;
   logic             bs_q, bs_d;
   logic             ce_q, ce_d;
   logic             pendValid_q, pendValid_d;
   logic [1:0]       pendOp_q, pendOp_d;
   logic             nextValid_q, nextValid_d;
   logic [1:0]       nextOp_q, nextOp_d;
   logic [2:0]       count_q, count_d;
   logic [1:0]       opSel_q, opSel_d;
   logic [WDW-1:0]   wdog_q, wdog_d;

   logic             isDigit;
   logic             isOperator;

   assign isDigit    = ~bufCode_q[4];
   assign isOperator = (bufCode_q >= KEY_ADD) && (bufCode_q <= KEY_MUL);

   // Next-state logic: the buffered key is only acted upon in IDLE or ERROR; pulses are registered.
   always_comb begin
      state_d     = state_q;
      bufValid_d  = bufValid_q;
      bufCode_d   = bufCode_q;
      keyLost_d   = key_valid_i & bufValid_q;
      newhex_d    = 1'b0;
      hexcode_d   = hexcode_q;
      newop_d     = 1'b0;
      bs_d        = 1'b0;
      ce_d        = 1'b0;
      pendValid_d = pendValid_q;
      pendOp_d    = pendOp_q;
      nextValid_d = nextValid_q;
      nextOp_d    = nextOp_q;
      count_d     = count_q;
      opSel_d     = opSel_q;
      wdog_d      = wdog_q;

      if (key_valid_i && !bufValid_q) begin
         bufValid_d = 1'b1;
         bufCode_d  = key_code_i;
      end

      unique case (state_q)
         IDLE: begin
            if (bufValid_q) begin
               bufValid_d = 1'b0;
               if (isDigit) begin
                  if (count_q < 3'd4) begin
                     newhex_d  = 1'b1;
                     hexcode_d = bufCode_q[3:0];
                     count_d   = count_q + 3'd1;
                  end
               end else if (bufCode_q == KEY_BS) begin
                  bs_d = 1'b1;
                  if (count_q != 3'd0) count_d = count_q - 3'd1;
               end else if (bufCode_q == KEY_CE) begin
                  ce_d    = 1'b1;
                  count_d = 3'd0;
               end else if (isOperator) begin
                  if (pendValid_q && (count_q != 3'd0)) begin
                     nextValid_d = 1'b1;
                     nextOp_d    = bufCode_q[1:0];
                     opSel_d     = pendOp_q;
                     state_d     = START;
                  end else if (pendValid_q) begin
                     pendOp_d = bufCode_q[1:0];
                  end else begin
                     newop_d     = 1'b1;
                     pendValid_d = 1'b1;
                     pendOp_d    = bufCode_q[1:0];
                     count_d     = 3'd0;
                  end
               end else if (bufCode_q == KEY_EQ) begin
                  if (pendValid_q) begin
                     nextValid_d = 1'b0;
                     opSel_d     = pendOp_q;
                     state_d     = START;
                  end
               end
            end
         end
         START: begin
            wdog_d  = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // A done in the same cycle as the timeout still wins.
            if (alu_done_i) begin
               state_d = alu_ovf_i ? ERROR : COMMIT_EQ;
            end else if (wdog_q >= WDW'(ALU_TIMEOUT - 1)) begin
               wdog_d  = WDW'(ALU_TIMEOUT);
               state_d = ERROR;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         COMMIT_EQ: begin
            count_d = 3'd0;
            if (nextValid_q) begin
               state_d = COMMIT_OP;
            end else begin
               pendValid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         COMMIT_OP: begin
            pendValid_d = 1'b1;
            pendOp_d    = nextOp_q;
            nextValid_d = 1'b0;
            state_d     = IDLE;
         end
         ERROR: begin
            if (bufValid_q) begin
               bufValid_d = 1'b0;
               if (bufCode_q == KEY_CE) begin
                  ce_d        = 1'b1;
                  pendValid_d = 1'b0;
                  nextValid_d = 1'b0;
                  count_d     = 3'd0;
                  state_d     = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and pulse registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         bufValid_q  <= 1'b0;
         bufCode_q   <= '0;
         keyLost_q   <= 1'b0;
         newhex_q    <= 1'b0;
         hexcode_q   <= '0;
         newop_q     <= 1'b0;
         bs_q        <= 1'b0;
         ce_q        <= 1'b0;
         pendValid_q <= 1'b0;
         pendOp_q    <= '0;
         nextValid_q <= 1'b0;
         nextOp_q    <= '0;
         count_q     <= '0;
         opSel_q     <= '0;
         wdog_q      <= '0;
      end else begin
         state_q     <= state_d;
         bufValid_q  <= bufValid_d;
         bufCode_q   <= bufCode_d;
         keyLost_q   <= keyLost_d;
         newhex_q    <= newhex_d;
         hexcode_q   <= hexcode_d;
         newop_q     <= newop_d;
         bs_q        <= bs_d;
         ce_q        <= ce_d;
         pendValid_q <= pendValid_d;
         pendOp_q    <= pendOp_d;
         nextValid_q <= nextValid_d;
         nextOp_q    <= nextOp_d;
         count_q     <= count_d;
         opSel_q     <= opSel_d;
         wdog_q      <= wdog_d;
      end
   end

   assign key_ready_o = ~bufValid_q;
   assign key_lost_o  = keyLost_q;
   assign newhex_o    = newhex_q;
   assign hexcode_o   = hexcode_q;
   assign newop_o     = newop_q | (state_q == COMMIT_OP);
   assign eq_o        = (state_q == COMMIT_EQ);
   assign BS_o        = bs_q;
   assign CE_o        = ce_q;
   assign op_sel_o    = opSel_q;
   assign alu_start_o = (state_q == START);
   assign busy_o      = (state_q != IDLE);
   assign err_o       = (state_q == ERROR);

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Directed bench for calc_key_sequencer: a vector table for single-key behaviour plus
// hand-written sequences for the ALU handshake, error, timeout, buffering and reset cases.
module tb_calc_key_sequencer;

   logic       clock = 1'b0;
   logic       reset;
   logic       keyValid;
   logic [4:0] keyCode;
   logic       keyReady, keyLost, newhex, newop, eq, bsOut, ceOut, aluStart, busy, err;
   logic [3:0] hexcode;
   logic [1:0] opSel;
   logic       aluDone, aluOvf;

   int vecCount  = 0;
   int missCount = 0;

   calc_key_sequencer #(.ALU_TIMEOUT(8)) dut (
      .clock(clock), .reset(reset),
      .key_valid_i(keyValid), .key_code_i(keyCode),
      .key_ready_o(keyReady), .key_lost_o(keyLost),
      .newhex_o(newhex), .hexcode_o(hexcode), .newop_o(newop), .eq_o(eq),
      .BS_o(bsOut), .CE_o(ceOut), .op_sel_o(opSel), .alu_start_o(aluStart),
      .alu_done_i(aluDone), .alu_ovf_i(aluOvf), .busy_o(busy), .err_o(err)
   );

   always #5 clock = ~clock;

   // Pulse vector order: {newhex, newop, eq, BS, CE, alu_start}
   logic [5:0] pulses;
   assign pulses = {newhex, newop, eq, bsOut, ceOut, aluStart};

   typedef struct {
      logic [4:0] code;
      logic [5:0] expPulse;
      logic [3:0] expHex;
   } vec_t;

   vec_t vecs[14];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic [4:0] code);
      keyValid = 1'b1;
      keyCode  = code;
      tick();
      keyValid = 1'b0;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyReset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got hang, expected finish");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      vecs[0]  = '{5'h01, 6'b100000, 4'h1};
      vecs[1]  = '{5'h02, 6'b100000, 4'h2};
      vecs[2]  = '{5'h03, 6'b100000, 4'h3};
      vecs[3]  = '{5'h04, 6'b100000, 4'h4};
      vecs[4]  = '{5'h05, 6'b000000, 4'h4};
      vecs[5]  = '{5'h14, 6'b000100, 4'h4};
      vecs[6]  = '{5'h09, 6'b100000, 4'h9};
      vecs[7]  = '{5'h0A, 6'b000000, 4'h9};
      vecs[8]  = '{5'h15, 6'b000010, 4'h9};
      vecs[9]  = '{5'h1F, 6'b000000, 4'h9};
      vecs[10] = '{5'h0B, 6'b100000, 4'hB};
      vecs[11] = '{5'h11, 6'b010000, 4'hB};
      vecs[12] = '{5'h10, 6'b000000, 4'hB};
      vecs[13] = '{5'h16, 6'b000000, 4'hB};

      reset = 1'b1; keyValid = 1'b0; keyCode = '0; aluDone = 1'b0; aluOvf = 1'b0;
      applyReset();
      checkOutput("reset_pulses", {2'b0, pulses}, 8'h00);
      checkOutput("reset_ready", {7'b0, keyReady}, 8'h01);
      checkOutput("reset_status", {4'b0, busy, err, opSel}, 8'h00);

      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].code);
         tick();
         checkOutput($sformatf("vec%0d_pulse", i), {2'b0, pulses}, {2'b0, vecs[i].expPulse});
         checkOutput($sformatf("vec%0d_hex", i), {4'b0, hexcode}, {4'b0, vecs[i].expHex});
      end

      // Basic equals: 7 + 3 =, done five cycles after alu_start
      applyReset();
      applyStimulus(5'h07); tick();
      applyStimulus(5'h10); tick();
      checkOutput("eq_newop_first", {7'b0, newop}, 8'h01);
      applyStimulus(5'h03); tick();
      applyStimulus(5'h13); tick();
      checkOutput("eq_start", {2'b0, pulses}, 8'h01);
      checkOutput("eq_opsel_start", {6'b0, opSel}, 8'h00);
      for (int i = 1; i <= 4; i++) begin
         tick();
         checkOutput($sformatf("eq_wait%0d", i), {4'b0, busy, eq, opSel}, 8'h08);
      end
      tick();
      aluDone = 1'b1;
      tick();
      aluDone = 1'b0;
      checkOutput("eq_pulse", {2'b0, pulses}, 8'h08);
      tick();
      checkOutput("eq_after", {1'b0, busy, pulses}, 8'h00);
      applyStimulus(5'h13); tick();
      checkOutput("eq_op_cleared", {6'b0, busy, aluStart}, 8'h00);

      // Chained operator: 7 + 3 * 2 =
      applyReset();
      applyStimulus(5'h07); tick();
      applyStimulus(5'h10); tick();
      applyStimulus(5'h03); tick();
      applyStimulus(5'h12); tick();
      checkOutput("chain_start", {2'b0, pulses}, 8'h01);
      checkOutput("chain_opsel_add", {6'b0, opSel}, 8'h00);
      tick();
      aluDone = 1'b1;
      tick();
      aluDone = 1'b0;
      checkOutput("chain_eq", {2'b0, pulses}, 8'h08);
      tick();
      checkOutput("chain_newop", {2'b0, pulses}, 8'h10);
      tick();
      checkOutput("chain_idle", {1'b0, busy, pulses}, 8'h00);
      applyStimulus(5'h02); tick();
      applyStimulus(5'h13); tick();
      checkOutput("chain_start2", {7'b0, aluStart}, 8'h01);
      checkOutput("chain_opsel_mul", {6'b0, opSel}, 8'h02);
      tick();
      aluDone = 1'b1;
      tick();
      aluDone = 1'b0;
      checkOutput("chain_eq2", {2'b0, pulses}, 8'h08);
      tick();
      checkOutput("chain_no_newop", {1'b0, busy, pulses}, 8'h00);

      // Overflow: error lockout, digits ignored, CE recovers
      applyStimulus(5'h10); tick();
      checkOutput("ovf_newop", {7'b0, newop}, 8'h01);
      applyStimulus(5'h04); tick();
      applyStimulus(5'h13); tick();
      checkOutput("ovf_start", {7'b0, aluStart}, 8'h01);
      tick();
      aluDone = 1'b1; aluOvf = 1'b1;
      tick();
      aluDone = 1'b0; aluOvf = 1'b0;
      checkOutput("ovf_err", {6'b0, err, eq}, 8'h02);
      applyStimulus(5'h06); tick();
      checkOutput("ovf_digit_ignored", {6'b0, err, newhex}, 8'h02);
      applyStimulus(5'h15); tick();
      checkOutput("ovf_ce", {5'b0, ceOut, err, busy}, 8'h04);
      applyStimulus(5'h13); tick();
      checkOutput("ovf_op_cleared", {6'b0, busy, aluStart}, 8'h00);

      // Timeout: ALU_TIMEOUT = 8, ERROR after exactly 8 WAIT cycles
      applyStimulus(5'h01); tick();
      applyStimulus(5'h10); tick();
      applyStimulus(5'h02); tick();
      applyStimulus(5'h13); tick();
      checkOutput("to_start", {7'b0, aluStart}, 8'h01);
      for (int i = 1; i <= 7; i++) tick();
      tick();
      checkOutput("to_wait8", {6'b0, busy, err}, 8'h02);
      tick();
      checkOutput("to_error", {6'b0, busy, err}, 8'h03);
      applyStimulus(5'h15); tick();
      checkOutput("to_recover", {6'b0, ceOut, err}, 8'h02);

      // Keys while busy: one buffered, the next is lost
      applyStimulus(5'h01); tick();
      applyStimulus(5'h10); tick();
      applyStimulus(5'h02); tick();
      applyStimulus(5'h13); tick();
      tick();
      applyStimulus(5'h03);
      checkOutput("buf_loaded", {6'b0, keyReady, keyLost}, 8'h00);
      applyStimulus(5'h04);
      checkOutput("buf_lost", {7'b0, keyLost}, 8'h01);
      aluDone = 1'b1;
      tick();
      aluDone = 1'b0;
      checkOutput("buf_lost_clear_eq", {6'b0, keyLost, eq}, 8'h01);
      tick();
      tick();
      checkOutput("buf_replay", {3'b0, newhex, hexcode}, 8'h13);

      // Reset in WAIT with a buffered key and a coincident done
      applyStimulus(5'h12); tick();
      applyStimulus(5'h05); tick();
      applyStimulus(5'h13); tick();
      checkOutput("rst_opsel_mul", {6'b0, opSel}, 8'h02);
      tick();
      applyStimulus(5'h07);
      reset = 1'b1; aluDone = 1'b1;
      tick();
      reset = 1'b0; aluDone = 1'b0;
      checkOutput("rst_pulses", {2'b0, pulses}, 8'h00);
      checkOutput("rst_status", {busy, err, keyReady, keyLost, 2'b0, opSel}, 8'h20);
      checkOutput("rst_hex", {4'b0, hexcode}, 8'h00);
      tick();
      checkOutput("rst_done_ignored", {1'b0, busy, pulses}, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule

// File: doc/calc_key_sequencer.md
# calc_key_sequencer

Command sequencer sitting between the debounced keypad decoder and the calculator datapath (V1/V2 operand registers plus a multi-cycle ALU). It turns one key event into the correctly ordered single-cycle pulses the operand registers expect (`newhex`/`hexcode`, `newop`, `eq`, `BS`, `CE`). It holds the pending operator and runs the ALU start/done handshake with a timeout watchdog. It also enforces digit-count and error-lockout rules, so the register block never sees conflicting controls.

## Interface
- `ALU_TIMEOUT`, default 64: cycles allowed from `alu_start` to `alu_done` before error.
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `key_valid`  in  1  key event present; one-cycle or held, see handshake.
- `key_code`  in  5  0x00–0x0F hex digit, 0x10 add, 0x11 sub, 0x12 mul, 0x13 equals, 0x14 backspace, 0x15 clear-entry; other codes ignored.
- `key_ready`  out  1  1 when the key buffer is empty.
- `key_lost`  out  1  one-cycle pulse: `key_valid` seen while buffer full.
- `newhex`  out  1  one-cycle digit pulse to the registers.
- `hexcode`  out  4  digit value, valid with `newhex`; holds last value otherwise.
- `newop`  out  1  one-cycle pulse, V2 <= V1.
- `eq`  out  1  one-cycle pulse, V1 <= answer.
- `BS`  out  1  one-cycle backspace pulse.
- `CE`  out  1  one-cycle clear-entry pulse.
- `op_sel`  out  2  ALU operation (00 add, 01 sub, 10 mul). Stable from `alu_start` until `alu_done`.
- `alu_start`  out  1  one-cycle ALU launch.
- `alu_done`  in  1  ALU result valid on `answer` this cycle.
- `alu_ovf`  in  1  overflow, qualified by `alu_done`.
- `busy`  out  1  state != IDLE.
- `err`  out  1  high in ERROR state.

## Operation
- **Reset values:** all outputs 0; state IDLE; buffer empty (`key_ready` = 1); no pending op; digit count 0; `op_sel` = 00.
- **Key buffer:** one entry. Load on `key_valid` & `key_ready`. When full, `key_valid` drops the key and pulses `key_lost`. The FSM consumes the entry only in IDLE or ERROR.
- **FSM states:** IDLE, START, WAIT, COMMIT_EQ, COMMIT_OP, ERROR.
- **IDLE, digit:**
  - Count < 4: pulse `newhex`, `hexcode` = `key_code[3:0]`, count++.
  - Count = 4: consume the key silently.
- **IDLE, BS:** pulse `BS`; count-- if > 0.
- **IDLE, CE:** pulse `CE`; count = 0. The pending op is kept.
- **IDLE, operator:**
  - Pending op and count > 0: latch the new op in `next_op`, then go to START.
  - Pending op and count = 0: replace the pending op only; no pulse.
  - No pending op: pulse `newop`; pending = new op; count = 0.
- **IDLE, equals:**
  - Pending op: go to START; `next_op` = none.
  - No pending op: ignore.
- **START:** `alu_start` = 1 with `op_sel` = pending op; reset the watchdog; go to WAIT.
- **WAIT:**
  - `alu_done` & !`alu_ovf`: go to COMMIT_EQ.
  - `alu_done` & `alu_ovf`: go to ERROR.
  - Watchdog reaches `ALU_TIMEOUT`: go to ERROR.
- **COMMIT_EQ:** pulse `eq`; count = 0.
  - `next_op` none: pending = none; go to IDLE.
  - Otherwise: go to COMMIT_OP.
- **COMMIT_OP:** pulse `newop`; pending = `next_op`; go to IDLE. This state is always at least one cycle after `eq`, so V2 captures the updated V1.
- **ERROR:**
  - `err` = 1; `eq` is never pulsed.
  - Only CE is accepted: pulse `CE`, clear pending op, count = 0, go to IDLE.
  - Any other buffered key is consumed and discarded.
- **Pulse exclusivity:** at most one of `newhex`/`newop`/`eq`/`BS`/`CE`/`alu_start` is high in any cycle.

## Timing
- **Key-to-pulse latency:** key accepted at edge t; the command pulse is registered high for the cycle after edge t+1.
- **Key throughput:** a new key can be accepted the cycle after consumption, so at most one key per 2 cycles.
- **Operator/equals sequence:** key at t → `alu_start` at t+1 → WAIT from t+2.
  - `alu_done` at edge d → `eq` in the cycle after d.
  - `newop` (operator key only) in the following cycle, then IDLE.
- **Watchdog:** the counter starts at 0 in WAIT and saturates; ERROR is entered on the edge where it equals `ALU_TIMEOUT`.
- **Keys while busy:** one key is buffered and processed on return to IDLE. Further keys pulse `key_lost`.
- **Reset mid-operation:** everything returns to reset values next edge; any in-flight `alu_done` is ignored.

## Test plan
- **Digit entry:** digits 1,2,3,4,5 → `newhex` pulses with 1,2,3,4 only; fifth digit produces no pulse; BS → `BS` pulse, count 3.
- **Basic equals:** 7, add, 3, equals; ALU `done` 5 cycles after `alu_start` → `op_sel` = 00 held through WAIT; `eq` one cycle after `done`; no `newop`; op cleared.
- **Chained operator:** 7, add, 3, mul, 2, equals → first mul key gives `eq` then `newop` on consecutive cycles; final `op_sel` = 10.
- **Overflow:** `alu_ovf` = 1 with `done` → `err` = 1, no `eq`; digit key ignored; CE → `CE` pulse, `err` = 0, IDLE.
- **Timeout:** `ALU_TIMEOUT` = 8, `done` never asserted → ERROR exactly 8 cycles into WAIT.
- **Buffer overflow and reset:** two keys presented while busy → first buffered, second `key_lost`; reset in WAIT → all outputs 0, `key_ready` = 1.
